// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run-control block: FSM states, host command opcodes, stop causes.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } run_state_t;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_BUDGET = 2'd1;
  localparam logic [1:0] CAUSE_CPU    = 2'd2;
  localparam logic [1:0] CAUSE_HOST   = 2'd3;

endpackage

// File: rtl/run_budget_counter.sv
// Loadable down-counter holding the remaining RUN budget minus one; zero means the current
// RUN cycle is the last one the budget allows. Saturates at zero.
module run_budget_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control front end for single_cycle_cpu: sequences CPU reset, gates execution via halt.
// Macro CPU_RUN_CTRL_BUDGET_EN enables the RUN cycle budget; otherwise RUN is unlimited.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic             cpu_stop_req,
  output logic             cpu_rst,
  output logic             cpu_halt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic [1:0]       done_cause
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  run_state_t       state_q, state_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             cpu_halt_q, cpu_halt_d;
  logic             accept, load_run, load_step, budget_exp;

  assign accept = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    cause_d   = cause_q;
    load_run  = 1'b0;
    load_step = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        cnt_d = '0;
        if (rcnt_q == RST_LAST) begin
          state_d = ST_IDLE;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          cause_d = CAUSE_NONE;
          unique case (cmd_op)
            OP_RESET: begin
              state_d = ST_RESET;
              rcnt_d  = '0;
              cnt_d   = '0;
            end
            OP_RUN: begin
              state_d  = ST_RUN;
              load_run = 1'b1;
            end
            OP_STEP: begin
              state_d   = ST_RUN;
              load_step = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        // RESET outranks every other exit and suppresses the done pulse.
        if (accept && (cmd_op == OP_RESET)) begin
          state_d = ST_RESET;
          rcnt_d  = '0;
          cnt_d   = '0;
          cause_d = CAUSE_NONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cpu_stop_req) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cause_d = CAUSE_CPU;
          end else if (budget_exp) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cause_d = CAUSE_BUDGET;
          end else if (accept && (cmd_op == OP_STOP)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            cause_d = CAUSE_HOST;
          end
        end
      end
      default: begin
        state_d = ST_RESET;
        rcnt_d  = '0;
        cnt_d   = '0;
      end
    endcase
    cmd_ready_d = (state_d != ST_RESET);
    cpu_rst_d   = (state_d == ST_RESET);
    cpu_halt_d  = (state_d != ST_RUN);
  end

`ifdef CPU_RUN_CTRL_BUDGET_EN
  // Counter holds budget-1 so its zero flag marks the final RUN cycle; lim_q=0 means unlimited.
  logic             lim_q, lim_d, bud_zero;
  logic [CNT_W-1:0] bud_load_val;

  assign bud_load_val = load_run ? (cmd_arg - CNT_W'(1)) : '0;

  always_comb begin
    lim_d = lim_q;
    if (load_run) begin
      lim_d = (cmd_arg != '0);
    end else if (load_step) begin
      lim_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim_q <= 1'b0;
    end else begin
      lim_q <= lim_d;
    end
  end

  run_budget_counter #(.CNT_W(CNT_W)) u_budget (
    .clk      (clk),
    .rst      (rst),
    .load     (load_run | load_step),
    .load_val (bud_load_val),
    .dec      (state_q == ST_RUN),
    .zero     (bud_zero)
  );

  assign budget_exp = lim_q && bud_zero;
`else
  logic step_q, step_d;
  logic unused_arg;

  assign unused_arg = ^cmd_arg;

  always_comb begin
    step_d = step_q;
    if (load_step) begin
      step_d = 1'b1;
    end else if (load_run) begin
      step_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_d;
    end
  end

  assign budget_exp = step_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RESET;
      rcnt_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      cmd_ready_q <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_halt_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      cmd_ready_q <= cmd_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_halt_q  <= cpu_halt_d;
    end
  end

  assign state      = state_q;
  assign cycle_cnt  = cnt_q;
  assign done       = done_q;
  assign done_cause = cause_q;
  assign cmd_ready  = cmd_ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign cpu_halt   = cpu_halt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with literal expectations plus a randomized
// command stream, all checked every cycle against a transaction-level model.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int CNT_W      = 32;
  localparam int RST_CYCLES = 4;
`ifdef CPU_RUN_CTRL_BUDGET_EN
  localparam bit BUD = 1'b1;
`else
  localparam bit BUD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_arg = '0;
  logic             cpu_stop_req = 1'b0;
  logic             cmd_ready, cpu_rst, cpu_halt, done;
  logic [1:0]       state, done_cause;
  logic [CNT_W-1:0] cycle_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .cpu_stop_req (cpu_stop_req),
    .cpu_rst      (cpu_rst),
    .cpu_halt     (cpu_halt),
    .state        (state),
    .cycle_cnt    (cycle_cnt),
    .done         (done),
    .done_cause   (done_cause)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=resetting, 1=idle, 2=running; runs_left counts remaining budget (0 = unlimited).
  int               m_mode;
  int               m_rst_left;
  longint           m_runs_left;
  logic [CNT_W-1:0] m_cnt;
  logic             m_done;
  logic [1:0]       m_cause;

  always @(posedge clk) begin
    bit acc;
    bit budget_over;
    if (rst) begin
      m_mode = 0; m_rst_left = RST_CYCLES; m_cnt = '0;
      m_done = 1'b0; m_cause = 2'd0; m_runs_left = 0;
    end else begin
      acc = cmd_valid && (m_mode != 0);
      m_done = 1'b0;
      if (m_mode == 0) begin
        m_cnt = '0;
        m_rst_left = m_rst_left - 1;
        if (m_rst_left == 0) m_mode = 1;
      end else if (m_mode == 1) begin
        if (acc) begin
          m_cause = 2'd0;
          if (cmd_op == OP_RESET) begin
            m_mode = 0; m_rst_left = RST_CYCLES; m_cnt = '0;
          end else if (cmd_op == OP_RUN) begin
            m_mode = 2; m_runs_left = BUD ? longint'(cmd_arg) : 0;
          end else if (cmd_op == OP_STEP) begin
            m_mode = 2; m_runs_left = 1;
          end
        end
      end else begin
        if (acc && cmd_op == OP_RESET) begin
          m_mode = 0; m_rst_left = RST_CYCLES; m_cnt = '0; m_cause = 2'd0;
        end else begin
          m_cnt = m_cnt + 1'b1;
          budget_over = 1'b0;
          if (m_runs_left != 0) begin
            m_runs_left = m_runs_left - 1;
            budget_over = (m_runs_left == 0);
          end
          if (cpu_stop_req) begin
            m_mode = 1; m_done = 1'b1; m_cause = 2'd2;
          end else if (budget_over) begin
            m_mode = 1; m_done = 1'b1; m_cause = 2'd1;
          end else if (acc && cmd_op == OP_STOP) begin
            m_mode = 1; m_done = 1'b1; m_cause = 2'd3;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("state", 64'(state), 64'(m_mode));
      chk("cmd_ready", 64'(cmd_ready), 64'(m_mode != 0));
      chk("cpu_rst", 64'(cpu_rst), 64'(m_mode == 0));
      chk("cpu_halt", 64'(cpu_halt), 64'(m_mode != 2));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
      chk("done", 64'(done), 64'(m_done));
      chk("done_cause", 64'(done_cause), 64'(m_cause));
    end
  end

  // Call at a falling edge: presents the command for one rising edge, returns one cycle later.
  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic reset_cmd();
    send(OP_RESET, '0);
    for (int i = 0; i < RST_CYCLES; i++) @(negedge clk);
  endtask

  int lows, pulses, highs;
  logic [1:0] cause_seen;

  initial begin
    // Reset release: four RESET cycles, then IDLE with a cleared counter.
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_rst) highs++;
    end
    chk("rel_rst_cycles", 64'(highs), 64'd4);
    chk("rel_state", 64'(state), 64'd1);
    chk("rel_ready", 64'(cmd_ready), 64'd1);
    chk("rel_cnt", 64'(cycle_cnt), 64'd0);

    // RUN with budget 10 (host STOP in the 10th cycle when the budget is compiled out).
    send(OP_RUN, 32'd10);
    lows = 0; pulses = 0; cause_seen = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (!cpu_halt) lows++;
      if (done) begin pulses++; cause_seen = done_cause; end
      cmd_op = OP_STOP;
      cmd_valid = (!BUD && i == 9);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("run10_low", 64'(lows), 64'd10);
    chk("run10_pulses", 64'(pulses), 64'd1);
    chk("run10_cause", 64'(cause_seen), BUD ? 64'd1 : 64'd3);
    chk("run10_cnt", 64'(cycle_cnt), 64'd10);

    // Three single steps from a fresh reset.
    reset_cmd();
    lows = 0; pulses = 0;
    for (int k = 0; k < 3; k++) begin
      send(OP_STEP, 32'd77);
      for (int i = 0; i < 3; i++) begin
        if (!cpu_halt) lows++;
        if (done) begin pulses++; cause_seen = done_cause; end
        @(negedge clk);
      end
    end
    chk("step_low", 64'(lows), 64'd3);
    chk("step_pulses", 64'(pulses), 64'd3);
    chk("step_cause", 64'(cause_seen), 64'd1);
    chk("step_cnt", 64'(cycle_cnt), 64'd3);

    // Unlimited RUN ended by the CPU in its 7th cycle.
    reset_cmd();
    send(OP_RUN, 32'd0);
    lows = 0; pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (!cpu_halt) lows++;
      if (done) begin pulses++; cause_seen = done_cause; end
      cpu_stop_req = (i == 6);
      @(negedge clk);
    end
    cpu_stop_req = 1'b0;
    chk("cpustop_low", 64'(lows), 64'd7);
    chk("cpustop_cause", 64'(cause_seen), 64'd2);
    chk("cpustop_cnt", 64'(cycle_cnt), 64'd7);

    // Stop request, host STOP and budget expiry all in the same cycle: CPU cause wins.
    reset_cmd();
    send(OP_RUN, 32'd5);
    lows = 0; pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (!cpu_halt) lows++;
      if (done) begin pulses++; cause_seen = done_cause; end
      cpu_stop_req = (i == 4);
      cmd_op = OP_STOP;
      cmd_valid = (i == 4);
      @(negedge clk);
    end
    cpu_stop_req = 1'b0; cmd_valid = 1'b0;
    chk("simul_low", 64'(lows), 64'd5);
    chk("simul_pulses", 64'(pulses), 64'd1);
    chk("simul_cause", 64'(cause_seen), 64'd2);
    chk("simul_cnt", 64'(cycle_cnt), 64'd5);

    // RESET command mid-run: four CPU reset cycles, no done pulse.
    send(OP_RUN, 32'd0);
    highs = 0; pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (cpu_rst) highs++;
      if (done) pulses++;
      cmd_op = OP_RESET;
      cmd_valid = (i == 3);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("rstcmd_cycles", 64'(highs), 64'd4);
    chk("rstcmd_pulses", 64'(pulses), 64'd0);
    chk("rstcmd_cnt", 64'(cycle_cnt), 64'd0);
    chk("rstcmd_state", 64'(state), 64'd1);

    // Block reset mid-run: outputs return to reset values without waiting for a clock.
    send(OP_RUN, 32'd0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("arst_halt", 64'(cpu_halt), 64'd1);
    chk("arst_ready", 64'(cmd_ready), 64'd0);
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_cnt", 64'(cycle_cnt), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_cause", 64'(done_cause), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("arst_idle", 64'(state), 64'd1);

    // Randomized command stream; the per-cycle comparator does the checking.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom % 3) == 0;
      cmd_op = 2'($urandom % 4);
      if (cmd_op == OP_RESET && ($urandom % 6) != 0) cmd_op = OP_RUN;
      cmd_arg = CNT_W'($urandom % 12);
      cpu_stop_req = ($urandom % 16) == 0;
      @(negedge clk);
    end
    cmd_valid = 1'b0; cpu_stop_req = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
